lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
`default_nettype none
//============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store unit controller. It runs one memory access per
//            request, sign- or zero-extends load data and returns a response.
//            Optional macro LSU_MISALIGN_TRAP_EN makes misaligned accesses fault.
// Revision : 1.0
//============================================================================
module lsu_ctrl #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RAM_BASE = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_ren,
   output logic            mem_wen,
   output logic [XLEN-1:0] mem_raddr,
   output logic [XLEN-1:0] mem_waddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [1:0]      mem_wdt_op,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam logic [1:0] c_WDT8  = 2'd0;
   localparam logic [1:0] c_WDT16 = 2'd1;
   localparam logic [1:0] c_WDT32 = 2'd2;
   localparam logic [1:0] c_WDT64 = 2'd3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      DATA = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_started;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [1:0]        r_size;
   logic              r_we;
   logic              r_unsigned;
   logic [XLEN-1:0]   r_rdata;
   logic              r_err;
   logic              w_misalign;
   logic              w_fault;
   logic [XLEN-1:0]   w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      w_misalign = 1'b0;
      case (req_size)
         2'd1:    w_misalign = req_addr[0];
         2'd2:    w_misalign = |req_addr[1:0];
         2'd3:    w_misalign = |req_addr[2:0];
         default: w_misalign = 1'b0;
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   assign w_fault = (req_addr < RAM_BASE) || w_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            // r_started keeps req_ready low until the first edge after reset.
            req_ready = r_started;
            if (req_valid && r_started) begin
               if (w_fault)     w_next = RESP;
               else if (req_we) w_next = WR;
               else             w_next = RD;
            end
         end
         RD: begin
            mem_ren = 1'b1;
            w_next  = DATA;
         end
         DATA: w_next = RESP;
         WR: begin
            mem_wen = 1'b1;
            w_next  = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ext = mem_rdata;
      case (r_size)
         2'd0: w_ext = {{(XLEN-8){~r_unsigned & mem_rdata[7]}},   mem_rdata[7:0]};
         2'd1: w_ext = {{(XLEN-16){~r_unsigned & mem_rdata[15]}}, mem_rdata[15:0]};
         2'd2: w_ext = {{(XLEN-32){~r_unsigned & mem_rdata[31]}}, mem_rdata[31:0]};
         default: w_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_started  <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= 2'd0;
         r_we       <= 1'b0;
         r_unsigned <= 1'b0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_started <= 1'b1;
         if (req_valid && req_ready) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_rdata    <= '0;
            r_err      <= w_fault;
         end else if (r_state == DATA && !r_we) begin
            r_rdata <= w_ext;
         end
      end
   end

   always_comb begin
      mem_wdt_op = c_WDT8;
      case (r_size)
         2'd1:    mem_wdt_op = c_WDT16;
         2'd2:    mem_wdt_op = c_WDT32;
         2'd3:    mem_wdt_op = c_WDT64;
         default: mem_wdt_op = c_WDT8;
      endcase
   end

   assign mem_raddr  = r_addr;
   assign mem_waddr  = r_addr;
   assign mem_wdata  = r_wdata;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
`default_nettype wire
